// File: rtl/picomips_ctrl_fsm.sv
// picoMIPS multi-cycle control unit: opcode decode, multiply stall,
// synchronised branch switch and optional flag-based branches.
module picomips_ctrl_fsm #(
    parameter int OP_W        = 6,
    parameter int MUL_LAT     = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FLAG_BR     = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic [3:0]      flags,
    input  logic            Bcond,
    input  logic            Bstus,
    input  logic            hold,
    output logic            PCincr,
    output logic            PCabsbranch,
    output logic            PCrelbranch,
    output logic [2:0]      ALUfunc,
    output logic            imm,
    output logic            fetch,
    output logic            show,
    output logic            w,
    output logic            busy,
    output logic            illegal
);

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'h01);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_ADDF = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_SUBI = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(6'h06);
    localparam logic [OP_W-1:0] OP_MULI = OP_W'(6'h07);
    localparam logic [OP_W-1:0] OP_SHOW = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_BAT  = OP_W'(6'h09);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h0A);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'h0B);
    localparam logic [OP_W-1:0] OP_BGE  = OP_W'(6'h0C);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(6'h0D);

    localparam logic [2:0] RNOP = 3'd0;
    localparam logic [2:0] RADD = 3'd1;
    localparam logic [2:0] RSUB = 3'd2;
    localparam logic [2:0] RMUL = 3'd3;

    localparam int CNT_W = 4;

    typedef enum logic {
        EXEC,
        MWAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   mimm_q, mimm_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    logic bstus_s;
    logic flag_n, flag_z, flag_c;
    logic br_take;
    logic unused_flag_v;

    assign bstus_s       = sync_q[SYNC_STAGES-1];
    assign flag_n        = flags[3];
    assign flag_z        = flags[2];
    assign flag_c        = flags[1];
    assign unused_flag_v = flags[0];
    assign PCabsbranch   = 1'b0;

    // Next-state and control decode for the current cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mimm_d  = mimm_q;
        sync_d[0] = Bstus;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        PCincr      = 1'b0;
        PCrelbranch = 1'b0;
        ALUfunc     = RNOP;
        imm         = 1'b0;
        fetch       = 1'b0;
        show        = 1'b0;
        w           = 1'b0;
        busy        = 1'b0;
        illegal     = 1'b0;
        br_take     = 1'b0;

        if (reset) begin
            state_d = EXEC;
        end else if (state_q == MWAIT) begin
            ALUfunc = RMUL;
            imm     = mimm_q;
            busy    = 1'b1;
            if (!hold) begin
                if (cnt_q == CNT_W'(1)) begin
                    w       = 1'b1;
                    PCincr  = 1'b1;
                    busy    = 1'b0;
                    state_d = EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end else begin
            PCincr = 1'b1;
            unique case (opcode)
                OP_NOP: ;
                OP_ADD: begin
                    w       = 1'b1;
                    ALUfunc = RADD;
                end
                OP_ADDI: begin
                    w       = 1'b1;
                    imm     = 1'b1;
                    ALUfunc = RADD;
                end
                OP_ADDF: begin
                    w       = 1'b1;
                    imm     = 1'b1;
                    fetch   = 1'b1;
                    ALUfunc = RADD;
                end
                OP_SUB: begin
                    w       = 1'b1;
                    ALUfunc = RSUB;
                end
                OP_SUBI: begin
                    w       = 1'b1;
                    imm     = 1'b1;
                    ALUfunc = RSUB;
                end
                OP_SHOW: begin
                    show    = 1'b1;
                    ALUfunc = RADD;
                end
                OP_MUL, OP_MULI: begin
                    ALUfunc = RMUL;
                    imm     = (opcode == OP_MULI);
                    if (MUL_LAT == 1) begin
                        w = 1'b1;
                    end else begin
                        PCincr  = 1'b0;
                        busy    = 1'b1;
                        state_d = MWAIT;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                        mimm_d  = (opcode == OP_MULI);
                    end
                end
                OP_BAT: br_take = (bstus_s == Bcond);
                OP_BEQ: begin
                    if (FLAG_BR != 0) br_take = flag_z;
                    else              illegal = 1'b1;
                end
                OP_BNE: begin
                    if (FLAG_BR != 0) br_take = !flag_z;
                    else              illegal = 1'b1;
                end
                OP_BGE: begin
                    if (FLAG_BR != 0) br_take = !flag_n;
                    else              illegal = 1'b1;
                end
                OP_BLT: begin
                    if (FLAG_BR != 0) br_take = flag_c;
                    else              illegal = 1'b1;
                end
                default: illegal = 1'b1;
            endcase

            if (br_take) begin
                PCincr      = 1'b0;
                PCrelbranch = 1'b1;
            end

            // A held instruction must not retire or start a multiply
            if (hold) begin
                PCincr      = 1'b0;
                PCrelbranch = 1'b0;
                w           = 1'b0;
                show        = 1'b0;
                state_d     = state_q;
                cnt_d       = cnt_q;
                mimm_d      = mimm_q;
            end
        end
    end

    // State, multiply counter and branch-switch synchroniser
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EXEC;
            cnt_q   <= '0;
            mimm_q  <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mimm_q  <= mimm_d;
            sync_q  <= sync_d;
        end
    end

endmodule

// File: tb/tb_picomips_ctrl_fsm.sv
// Directed bench for picomips_ctrl_fsm: a MUL_LAT=3/FLAG_BR=1 instance
// and a single-cycle MUL_LAT=1/FLAG_BR=0 instance share one stimulus.
module tb_picomips_ctrl_fsm;

    localparam logic [5:0] NOP  = 6'h00;
    localparam logic [5:0] ADD  = 6'h01;
    localparam logic [5:0] ADDI = 6'h02;
    localparam logic [5:0] ADDF = 6'h03;
    localparam logic [5:0] SUB  = 6'h04;
    localparam logic [5:0] SUBI = 6'h05;
    localparam logic [5:0] MUL  = 6'h06;
    localparam logic [5:0] MULI = 6'h07;
    localparam logic [5:0] SHOW = 6'h08;
    localparam logic [5:0] BAT  = 6'h09;
    localparam logic [5:0] BEQ  = 6'h0A;
    localparam logic [5:0] BNE  = 6'h0B;
    localparam logic [5:0] BGE  = 6'h0C;
    localparam logic [5:0] BLT  = 6'h0D;
    localparam logic [5:0] BAD  = 6'h3F;

    localparam logic [2:0] RNOP = 3'd0;
    localparam logic [2:0] RADD = 3'd1;
    localparam logic [2:0] RSUB = 3'd2;
    localparam logic [2:0] RMUL = 3'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [3:0] flags;
    logic       Bcond, Bstus, hold;

    logic       a_pc, a_abs, a_rel, a_imm, a_fet, a_shw, a_w, a_bsy, a_ill;
    logic [2:0] a_alu;
    logic       b_pc, b_abs, b_rel, b_imm, b_fet, b_shw, b_w, b_bsy, b_ill;
    logic [2:0] b_alu;

    logic [11:0] va, vb;
    int checks = 0;
    int errors = 0;
    int wcnt   = 0;
    int wbase;

    always #5 clk = ~clk;

    picomips_ctrl_fsm #(
        .OP_W(6), .MUL_LAT(3), .SYNC_STAGES(2), .FLAG_BR(1)
    ) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .flags(flags),
        .Bcond(Bcond), .Bstus(Bstus), .hold(hold),
        .PCincr(a_pc), .PCabsbranch(a_abs), .PCrelbranch(a_rel),
        .ALUfunc(a_alu), .imm(a_imm), .fetch(a_fet), .show(a_shw),
        .w(a_w), .busy(a_bsy), .illegal(a_ill)
    );

    picomips_ctrl_fsm #(
        .OP_W(6), .MUL_LAT(1), .SYNC_STAGES(1), .FLAG_BR(0)
    ) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .flags(flags),
        .Bcond(Bcond), .Bstus(Bstus), .hold(hold),
        .PCincr(b_pc), .PCabsbranch(b_abs), .PCrelbranch(b_rel),
        .ALUfunc(b_alu), .imm(b_imm), .fetch(b_fet), .show(b_shw),
        .w(b_w), .busy(b_bsy), .illegal(b_ill)
    );

    assign va = {a_pc, a_abs, a_rel, a_alu, a_imm, a_fet,
                 a_shw, a_w, a_bsy, a_ill};
    assign vb = {b_pc, b_abs, b_rel, b_alu, b_imm, b_fet,
                 b_shw, b_w, b_bsy, b_ill};

    // Count register writes of the multi-cycle instance
    always @(posedge clk) begin
        if (a_w) wcnt <= wcnt + 1;
    end

    function automatic logic [11:0] e(
        input logic pc, input logic rel, input logic [2:0] alu,
        input logic im, input logic fe, input logic sh,
        input logic wr, input logic bs, input logic il
    );
        return {pc, 1'b0, rel, alu, im, fe, sh, wr, bs, il};
    endfunction

    task automatic chk(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        opcode = ADD;
        flags  = 4'b0000;
        Bcond  = 1'b0;
        Bstus  = 1'b0;
        hold   = 1'b0;

        at_neg; chk("rst0", va, '0); chk("rst0_b", vb, '0);
        nxt;
        at_neg; chk("rst1", va, '0);
        nxt;
        reset = 1'b0;
        at_neg; chk("add", va, e(1,0,RADD,0,0,0,1,0,0));
        nxt;

        opcode = ADDI;
        at_neg; chk("addi", va, e(1,0,RADD,1,0,0,1,0,0));
        nxt;
        opcode = ADDF;
        at_neg; chk("addf", va, e(1,0,RADD,1,1,0,1,0,0));
        nxt;
        opcode = SUB;
        at_neg; chk("sub", va, e(1,0,RSUB,0,0,0,1,0,0));
        nxt;
        opcode = SUBI;
        at_neg; chk("subi", va, e(1,0,RSUB,1,0,0,1,0,0));
        nxt;
        opcode = SHOW;
        at_neg; chk("show", va, e(1,0,RADD,0,0,1,0,0,0));
        nxt;
        opcode = NOP;
        at_neg; chk("nop", va, e(1,0,RNOP,0,0,0,0,0,0));
        nxt;

        // MULI on the 3-cycle instance, opcode changed mid-flight
        wbase  = wcnt;
        opcode = MULI;
        at_neg; chk("muli_c1", va, e(0,0,RMUL,1,0,0,0,1,0));
        chk("muli_b", vb, e(1,0,RMUL,1,0,0,1,0,0));
        nxt;
        opcode = ADD;
        at_neg; chk("muli_c2", va, e(0,0,RMUL,1,0,0,0,1,0));
        nxt;
        at_neg; chk("muli_c3", va, e(1,0,RMUL,1,0,0,1,0,0));
        nxt;
        opcode = NOP;
        at_neg; chk("muli_after", va, e(1,0,RNOP,0,0,0,0,0,0));
        chk("muli_wcnt", 12'(wcnt - wbase), 12'd1);
        nxt;

        // MUL with hold on cycles 2-3
        wbase  = wcnt;
        opcode = MUL;
        at_neg; chk("mh_c1", va, e(0,0,RMUL,0,0,0,0,1,0));
        nxt;
        hold = 1'b1;
        opcode = NOP;
        at_neg; chk("mh_c2", va, e(0,0,RMUL,0,0,0,0,1,0));
        nxt;
        at_neg; chk("mh_c3", va, e(0,0,RMUL,0,0,0,0,1,0));
        nxt;
        hold = 1'b0;
        at_neg; chk("mh_c4", va, e(0,0,RMUL,0,0,0,0,1,0));
        nxt;
        at_neg; chk("mh_c5", va, e(1,0,RMUL,0,0,0,1,0,0));
        nxt;
        at_neg; chk("mh_after", va, e(1,0,RNOP,0,0,0,0,0,0));
        chk("mh_wcnt", 12'(wcnt - wbase), 12'd1);
        nxt;

        // Reset while waiting on a multiply
        wbase  = wcnt;
        opcode = MUL;
        at_neg; chk("mr_c1", va, e(0,0,RMUL,0,0,0,0,1,0));
        nxt;
        reset = 1'b1;
        at_neg; chk("mr_rst", va, '0);
        nxt;
        reset  = 1'b0;
        opcode = NOP;
        at_neg; chk("mr_exec", va, e(1,0,RNOP,0,0,0,0,0,0));
        nxt;
        at_neg; chk("mr_wcnt", 12'(wcnt - wbase), 12'd0);
        nxt;

        // hold in EXEC freezes retirement but decodes the ALU
        opcode = ADD;
        hold   = 1'b1;
        at_neg; chk("hold_add", va, e(0,0,RADD,0,0,0,0,0,0));
        nxt;
        hold = 1'b0;
        at_neg; chk("hold_rel", va, e(1,0,RADD,0,0,0,1,0,0));
        nxt;

        // BAT through the switch synchroniser
        opcode = BAT;
        Bcond  = 1'b1;
        Bstus  = 1'b1;
        at_neg; chk("bat_c0", va, e(1,0,RNOP,0,0,0,0,0,0));
        nxt;
        at_neg; chk("bat_c1", va, e(1,0,RNOP,0,0,0,0,0,0));
        chk("bat_b_c1", vb, e(0,1,RNOP,0,0,0,0,0,0));
        nxt;
        at_neg; chk("bat_c2", va, e(0,1,RNOP,0,0,0,0,0,0));
        nxt;
        Bcond = 1'b0;
        at_neg; chk("bat_nt", va, e(1,0,RNOP,0,0,0,0,0,0));
        nxt;

        // Flag branches
        opcode = BEQ;
        flags  = 4'b0100;
        at_neg; chk("beq_t", va, e(0,1,RNOP,0,0,0,0,0,0));
        chk("beq_ill_b", vb, e(1,0,RNOP,0,0,0,0,0,1));
        nxt;
        flags = 4'b0000;
        at_neg; chk("beq_nt", va, e(1,0,RNOP,0,0,0,0,0,0));
        nxt;
        opcode = BNE;
        at_neg; chk("bne_t", va, e(0,1,RNOP,0,0,0,0,0,0));
        nxt;
        opcode = BGE;
        flags  = 4'b1000;
        at_neg; chk("bge_nt", va, e(1,0,RNOP,0,0,0,0,0,0));
        nxt;
        opcode = BLT;
        flags  = 4'b0010;
        at_neg; chk("blt_t", va, e(0,1,RNOP,0,0,0,0,0,0));
        nxt;

        // Unassigned opcode behaves as NOP with illegal flagged
        opcode = BAD;
        at_neg; chk("ill", va, e(1,0,RNOP,0,0,0,0,0,1));
        nxt;
        opcode = ADD;
        at_neg; chk("ill_after", va, e(1,0,RADD,0,0,0,1,0,0));
        nxt;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/picomips_ctrl_fsm.md
Name: picomips_ctrl_fsm

Overview:
- Multi-cycle successor to the picoMIPS single-cycle instruction decoder.
- Decodes the 6-bit opcode into PC, ALU, immediate-mux, fetch-mux, display and register-write controls.
- Adds three things the single-cycle decoder lacks:
  - a parametrised multi-cycle multiply stall;
  - a synchronised branch-switch input;
  - optional flag-based conditional branches.
- Sits between program memory and the datapath/PC in the picoMIPS top level.

Parameters:
- OP_W, 6, opcode width; encodings are the codebase opcode macros.
- MUL_LAT, 1, cycles for MUL/MULI (1..8). Value 1 gives single-cycle behaviour.
- SYNC_STAGES, 2, flip-flop stages on Bstus (1..3).
- FLAG_BR, 0, when 1, BEQ/BNE/BGE/BLT are decoded. When 0, they are illegal.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- opcode  in  OP_W  top bits of current instruction
- flags  in  4  ALU flags {N,Z,C,V}
- Bcond  in  1  branch condition bit from instruction
- Bstus  in  1  asynchronous branch-status switch
- hold  in  1  freeze request (display pause)
- PCincr  out  1  PC increment
- PCabsbranch  out  1  absolute branch, always 0 in this generation
- PCrelbranch  out  1  relative branch
- ALUfunc  out  3  ALU function code (RNOP/RADD/RSUB/RMUL)
- imm  out  1  immediate operand mux select
- fetch  out  1  input-port operand mux select
- show  out  1  display latch enable
- w  out  1  register-file write enable
- busy  out  1  multi-cycle operation in progress
- illegal  out  1  unimplemented opcode in current cycle

Behaviour:

Reset and general rules:
- Reset is synchronous and active-high, with one clock.
- While reset=1: state=EXEC, counter=0, Bstus synchroniser cleared to 0. All outputs are 0 and ALUfunc=RNOP; PCincr is also 0.
- Outputs are combinational from {state, opcode, flags, Bcond, synchronised Bstus, hold, counter}. Only state, counter and the synchroniser are registered.

State EXEC, single-cycle decode:
- Defaults: PCincr=1, ALUfunc=RNOP, all other controls 0.
- ADD: w=1, RADD.
- ADDI: w=1, imm=1, RADD.
- ADDF: w=1, imm=1, fetch=1, RADD.
- SUB: w=1, RSUB.
- SUBI: w=1, imm=1, RSUB.
- SHOW: show=1, RADD.
- NOP: defaults.

State EXEC, MUL/MULI:
- With MUL_LAT=1: w=1, RMUL (imm=1 for MULI), single cycle.
- With MUL_LAT>1: first cycle gives ALUfunc=RMUL, imm as per opcode, w=0, PCincr=0, busy=1. Next state MWAIT, counter=MUL_LAT-1.

State MWAIT:
- ALUfunc=RMUL and imm are held from the latched opcode type. busy=1 and PCincr=0.
- counter decrements each cycle.
- When counter==1: w=1, PCincr=1, busy=0, next state EXEC.
- Total MUL latency is exactly MUL_LAT cycles. The write occurs only in the last cycle.

Branches:
- BAT: taken when sync(Bstus)==Bcond. Bstus passes SYNC_STAGES flops, so a switch change is visible SYNC_STAGES cycles later.
- If FLAG_BR=1:
  - BEQ taken when Z=1
  - BNE taken when Z=0
  - BGE taken when N=0
  - BLT taken when C=1
- Taken branch: PCincr=0, PCrelbranch=1. Not taken: PCincr=1.
- A branch never enters MWAIT.

Illegal opcodes:
- illegal=1 for the cycle and the instruction is treated as NOP (PCincr=1).
- No simulation-only error is used as control.

hold:
- In EXEC: PCincr, PCrelbranch, w and show are all forced to 0 and the state is unchanged. ALUfunc, imm and fetch still decode.
- In MWAIT: counter freezes, busy stays 1, and w/PCincr are suppressed even when counter==1.
- When hold drops, operation resumes with no lost or duplicated write.

Other boundary conditions:
- Reset during MWAIT: next state is EXEC, no write occurs, busy=0.
- Opcode changes during MWAIT are ignored; the MUL completes using the latched type.

Test Plan:
- reset=1 for 2 cycles with opcode=ADD -> all outputs 0 and ALUfunc=RNOP. On the first cycle after release: w=1, PCincr=1, ALUfunc=RADD.
- MUL_LAT=3, MULI issued -> cycles 1-2: busy=1, PCincr=0, w=0, imm=1, ALUfunc=RMUL. Cycle 3: w=1, PCincr=1, busy=0. Exactly one write in total.
- MUL_LAT=3, hold=1 on cycle 2 for 2 cycles -> counter frozen, no write. w=1 arrives on the 5th cycle, once only. Reset asserted in MWAIT instead -> w never asserts.
- SYNC_STAGES=2, BAT with Bcond=1, Bstus rises at cycle 0 -> PCrelbranch=0 for cycles 0-1 and PCrelbranch=1, PCincr=0 from cycle 2.
- FLAG_BR=1, BEQ with flags=4'b0100 -> PCrelbranch=1. BEQ with flags=4'b0000 -> PCincr=1. FLAG_BR=0, BEQ -> illegal=1, PCincr=1.
- Unassigned opcode 6'h3F -> illegal=1, w=0, PCincr=1, no state change.
